// File: rtl/memory_port.sv
// Byte-addressed, big-endian memory port. An access covers one word of bytes
// starting at any byte address; unaligned accesses take a second cycle for word A+1.
module memory_port #(
  parameter  int N = 32,
  parameter  int M = 10,
  localparam int B = N / 8,
  localparam int O = $clog2(B)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [M+O-1:0] address,
  input  logic           wf,
  input  logic [N-1:0]   mask,
  input  logic [N-1:0]   w,
  output logic           resp_valid,
  output logic [N-1:0]   v
);

  // state  | meaning
  // IDLE   | ready; aligned accesses complete here in one edge
  // PHASE2 | second half of an unaligned access, touches word A+1
  typedef enum logic {IDLE = 1'b0, PHASE2 = 1'b1} state_e;

  localparam logic [O+3:0] N_W = (O+4)'(N);

  state_e         state_q, state_d;
  logic           rdy_q;
  logic           resp_q, resp_d;
  logic [N-1:0]   v_q, v_d;

  logic           wf_q, wf_d;
  logic [O-1:0]   off_q, off_d;
  logic [M-1:0]   a_q, a_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [N-1:0]   w_q, w_d;
  logic [N-1:0]   part_q, part_d;

  logic [N-1:0]   mem_q [2**M];
  logic           mem_we;
  logic [M-1:0]   mem_idx;
  logic [N-1:0]   mem_wd, mem_wm, mem_rd;

  logic [M-1:0]   word_a;
  logic [O-1:0]   off_in;
  logic [O+3:0]   sh_in, rsh_q;

  assign word_a  = address[M+O-1:O];
  assign off_in  = address[O-1:0];
  assign sh_in   = {1'b0, off_in, 3'b000};
  // Bit distance of the window's tail bytes from the top of word A+1.
  assign rsh_q   = N_W - {1'b0, off_q, 3'b000};
  assign mem_rd  = mem_q[mem_idx];

  assign req_ready  = rdy_q & (state_q == IDLE);
  assign resp_valid = resp_q;
  assign v          = v_q;

  always_comb begin
    state_d = state_q;
    resp_d  = 1'b0;
    v_d     = v_q;
    wf_d    = wf_q;
    off_d   = off_q;
    a_d     = a_q;
    mask_d  = mask_q;
    w_d     = w_q;
    part_d  = part_q;
    mem_we  = 1'b0;
    mem_idx = word_a;
    mem_wd  = '0;
    mem_wm  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          // Window byte 0 lands on word byte off: shift the window right.
          mem_we = wf;
          mem_wd = w >> sh_in;
          mem_wm = mask >> sh_in;
          if (off_in == '0) begin
            resp_d = 1'b1;
            if (!wf) v_d = mem_rd;
          end else begin
            state_d = PHASE2;
            wf_d    = wf;
            off_d   = off_in;
            a_d     = word_a;
            mask_d  = mask;
            w_d     = w;
            part_d  = mem_rd << sh_in;
          end
        end
      end
      PHASE2: begin
        mem_idx = a_q + M'(1);
        mem_we  = wf_q;
        mem_wd  = w_q << rsh_q;
        mem_wm  = mask_q << rsh_q;
        if (!wf_q) v_d = part_q | (mem_rd >> rsh_q);
        resp_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      v_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      v_q     <= v_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    wf_q   <= wf_d;
    off_q  <= off_d;
    a_q    <= a_d;
    mask_q <= mask_d;
    w_q    <= w_d;
    part_q <= part_d;
  end

  // Contents survive reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_idx] <= (mem_rd & ~mem_wm) | (mem_wd & mem_wm);
  end

endmodule
